// File: rtl/solver_frame_sequencer.sv
// Byte-stream front end for the Solver core: assembles a command frame, presents it,
// waits a fixed solve latency, then returns the captured result over valid/ready.
module solver_frame_sequencer #(
    parameter int SOLVE_CYCLES = 2  // legal range 1..15
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [59:0] sol_data_raw,
    output logic [77:0] sol_data_enc,
    output logic [1:0]  sol_work,
    input  logic [77:0] sol_out_enc,
    input  logic [59:0] sol_out_raw,
    output logic [77:0] res_data,
    output logic [1:0]  res_mode,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        err_illegal,
    output logic        busy,
    output logic [2:0]  dbgState
);

    // Handshakes: a byte moves on in_valid && in_ready, a result on res_valid && res_ready;
    // both ready/valid outputs are registered, so neither depends on its partner this cycle.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD       = 3'd1,
        PRESENT    = 3'd2,
        SOLVE_WAIT = 3'd3,
        RESP       = 3'd4
    } seqState_t;

    seqState_t   state;
    logic [1:0]  curMode;
    logic [79:0] asmBuf;
    logic [3:0]  byteCnt;
    logic [3:0]  waitCnt;
    logic        accept;
    logic [3:0]  lastIdx;

    assign accept   = in_valid && in_ready;
    assign lastIdx  = (curMode == 2'd1) ? 4'd9 : 4'd7;
    assign busy     = (state != IDLE);
    assign dbgState = state;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state        <= IDLE;
            curMode      <= 2'd0;
            asmBuf       <= '0;
            byteCnt      <= '0;
            waitCnt      <= '0;
            in_ready     <= 1'b0;
            sol_data_raw <= '0;
            sol_data_enc <= '0;
            sol_work     <= '0;
            res_data     <= '0;
            res_mode     <= '0;
            res_valid    <= 1'b0;
            err_illegal  <= 1'b0;
        end else begin
            err_illegal <= 1'b0;
            case (state)
                IDLE: begin
                    // Also raises in_ready on the first cycle out of reset.
                    in_ready <= 1'b1;
                    if (accept) begin
                        curMode <= in_byte[1:0];
                        case (in_byte[1:0])
                            2'd0, 2'd1: begin
                                asmBuf  <= '0;
                                byteCnt <= '0;
                                state   <= LOAD;
                            end
                            2'd2: begin
                                in_ready <= 1'b0;
                                state    <= PRESENT;
                            end
                            default: err_illegal <= 1'b1;
                        endcase
                    end
                end
                LOAD: begin
                    if (accept) begin
                        asmBuf[{byteCnt, 3'b000} +: 8] <= in_byte;
                        byteCnt <= byteCnt + 4'd1;
                        if (byteCnt == lastIdx) begin
                            in_ready <= 1'b0;
                            state    <= PRESENT;
                        end
                    end
                end
                PRESENT: begin
                    // The data port the mode does not use keeps its old value.
                    sol_work <= curMode;
                    if (curMode == 2'd0) sol_data_raw <= asmBuf[59:0];
                    if (curMode == 2'd1) sol_data_enc <= asmBuf[77:0];
                    waitCnt <= 4'(SOLVE_CYCLES - 1);
                    state   <= SOLVE_WAIT;
                end
                SOLVE_WAIT: begin
                    if (waitCnt == 4'd0) begin
                        res_data  <= (curMode == 2'd0) ? sol_out_enc : {18'b0, sol_out_raw};
                        res_mode  <= curMode;
                        res_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        waitCnt <= waitCnt - 4'd1;
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    in_ready <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
